cr_sensor_request: RTL and testbench

//   Front end for the country-road vehicle loop detector. Drives the controller's `sensor` request.

---
 rtl/tl_pkg.sv | 16 +
 rtl/sensor_debounce.sv | 55 +++++
 rtl/cr_sensor_request.sv | 122 ++++++++++++
 tb/tb_cr_sensor_request.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light types and default sizing for the country-road request path.
// Contents: cr_req_state_t (request FSM states) and the default parameter values
// used by cr_sensor_request and its debounce block.
package tl_pkg;

  typedef enum logic [1:0] {
    CRQ_IDLE  = 2'd0,
    CRQ_REQ   = 2'd1,
    CRQ_SERVE = 2'd2
  } cr_req_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYC = 16;
  localparam int unsigned DEF_COUNT_W      = 4;
  localparam int unsigned DEF_STUCK_S      = 60;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus level debouncer for a mechanical or loop input.
// A new synchronised level is accepted once it has persisted DEBOUNCE_CYC
// consecutive cycles; arrive/depart are 1-cycle strobes issued on acceptance.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   raw       asynchronous input level
//   stable    debounced level
//   arrive    strobe, stable went 0->1
//   depart    strobe, stable went 1->0
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic arrive,
  output logic depart
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count consecutive cycles the synced level disagrees with stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      arrive <= 1'b0;
      depart <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      arrive <= 1'b0;
      depart <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        arrive <= sync2;
        depart <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cr_sensor_request.sv
// Country-road vehicle request front end: debounces the loop detector, keeps a
// saturating count of queued vehicles and holds `sensor` until the CR green
// phase has served the queue.
// Optional feature macro: STUCK_FAULT_EN (stuck-loop detector; latches fault,
// forces sensor high and freezes count/FSM). Without it fault is always 0.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   sensor_raw  raw loop level, asynchronous, 1 = occupied
//   pulse       1-cycle strobe once per second
//   cr_ena      1 while the CR green phase is served
//   sensor      registered request to the highway controller
//   veh_count   registered vehicles queued or being served
//   fault       registered, sticky stuck-loop fault
module cr_sensor_request
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned COUNT_W      = DEF_COUNT_W,
  parameter int unsigned STUCK_S      = DEF_STUCK_S
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor_raw,
  input  logic               pulse,
  input  logic               cr_ena,
  output logic               sensor,
  output logic [COUNT_W-1:0] veh_count,
  output logic               fault
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic               stable;
  logic               arrive;
  logic               depart;
  cr_req_state_t      state;
  cr_req_state_t      state_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               sensor_nxt;
  logic               fault_nxt;

  sensor_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw    (sensor_raw),
    .stable (stable),
    .arrive (arrive),
    .depart (depart)
  );

`ifdef STUCK_FAULT_EN
  localparam int unsigned OCC_W = $clog2(STUCK_S + 1);
  localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(STUCK_S - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(STUCK_S);

  logic [OCC_W-1:0] occ_sec;

  // Seconds of continuous occupancy; saturates at STUCK_S.
  always_ff @(posedge clk) begin
    if (rst || !stable) begin
      occ_sec <= '0;
    end else if (pulse && occ_sec != OCC_MAX) begin
      occ_sec <= occ_sec + OCC_W'(1);
    end
  end

  assign fault_nxt = fault | (stable & pulse & (occ_sec == OCC_LAST));
`else
  logic unused_cfg;
  assign unused_cfg = pulse ^ stable ^ (STUCK_S == 0);
  assign fault_nxt  = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CRQ_IDLE;
      veh_count <= '0;
      sensor    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      veh_count <= count_nxt;
      sensor    <= sensor_nxt;
      fault     <= fault_nxt;
    end
  end

  // Next state, next count and next request; a latched fault freezes everything.
  always_comb begin
    state_nxt  = state;
    count_nxt  = veh_count;
    sensor_nxt = 1'b0;

    if (!fault) begin
      if (arrive && veh_count != COUNT_MAX) begin
        count_nxt = veh_count + COUNT_W'(1);
      end else if (depart && state == CRQ_SERVE && veh_count != '0) begin
        count_nxt = veh_count - COUNT_W'(1);
      end

      case (state)
        CRQ_IDLE:  if (arrive) state_nxt = CRQ_REQ;
        CRQ_REQ:   if (cr_ena) state_nxt = CRQ_SERVE;
        // Exit decision uses the count already updated this cycle.
        CRQ_SERVE: if (!cr_ena) state_nxt = (count_nxt != '0) ? CRQ_REQ : CRQ_IDLE;
        default:   state_nxt = CRQ_IDLE;
      endcase
    end

    case (state_nxt)
      CRQ_REQ:   sensor_nxt = 1'b1;
      CRQ_SERVE: sensor_nxt = (count_nxt != '0);
      default:   sensor_nxt = 1'b0;
    endcase

    if (fault_nxt) sensor_nxt = 1'b1;
  end

endmodule

// File: tb/tb_cr_sensor_request.sv
// Self-checking bench for cr_sensor_request: directed steps followed by a
// randomised run, all compared against a behavioural model of the request rules.
module tb_cr_sensor_request;

  localparam int D    = 16;
  localparam int CW   = 4;
  localparam int SS   = 5;
  localparam int MAXC = 15;
`ifdef STUCK_FAULT_EN
  localparam int FAULT_ON = 1;
`else
  localparam int FAULT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sensor_raw;
  logic          pulse;
  logic          cr_ena;
  logic          sensor;
  logic [CW-1:0] veh_count;
  logic          fault;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = no request, 1 = waiting for green, 2 = green serving.
  int q_sync[$];
  int win[$];
  int m_stable, m_arr, m_dep, m_phase, m_cnt, m_sensor, m_fault, m_occ;

  always #5 clk = ~clk;

  cr_sensor_request #(
    .DEBOUNCE_CYC(D),
    .COUNT_W     (CW),
    .STUCK_S     (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .pulse      (pulse),
    .cr_ena     (cr_ena),
    .sensor     (sensor),
    .veh_count  (veh_count),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply the request rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int s;
    int c;
    int all_same;
    int fault_new;
    if (rst) begin
      q_sync = '{0, 0};
      win.delete();
      m_stable = 0; m_arr = 0; m_dep = 0; m_phase = 0;
      m_cnt = 0; m_sensor = 0; m_fault = 0; m_occ = 0;
      return;
    end
    fault_new = m_fault;
    if (FAULT_ON != 0) begin
      if (m_stable == 1) begin
        if (pulse) m_occ++;
      end else begin
        m_occ = 0;
      end
      if (m_occ >= SS) fault_new = 1;
    end
    if (m_fault == 0) begin
      c = m_cnt;
      if (m_arr != 0) c = (c < MAXC) ? c + 1 : c;
      else if (m_dep != 0 && m_phase == 2 && c > 0) c = c - 1;
      if (m_phase == 0) begin
        if (m_arr != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (cr_ena) m_phase = 2;
      end else begin
        if (!cr_ena) m_phase = (c != 0) ? 1 : 0;
      end
      m_cnt = c;
    end
    m_fault  = fault_new;
    m_sensor = (m_fault != 0) ? 1 : (m_phase == 1) ? 1 : (m_phase == 2) ? int'(m_cnt != 0) : 0;
    // Level seen after two synchroniser stages; accepted once the last D samples agree.
    s = q_sync.pop_front();
    q_sync.push_back(int'(sensor_raw));
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    m_arr = 0;
    m_dep = 0;
    all_same = (win.size() == D) ? 1 : 0;
    foreach (win[i]) if (win[i] != s) all_same = 0;
    if (all_same != 0 && s != m_stable) begin
      m_stable = s;
      m_arr = s;
      m_dep = 1 - s;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_sensor", 32'(sensor), 32'(m_sensor));
    check("model_veh_count", 32'(veh_count), 32'(m_cnt));
    check("model_fault", 32'(fault), 32'(m_fault));
  endtask

  initial begin
    int raw_hold;
    int ena_hold;
    rst = 1'b1; sensor_raw = 1'b1; pulse = 1'b0; cr_ena = 1'b0;

    // Reset with the loop occupied: everything stays low.
    repeat (3) begin
      tick();
      check("rst_sensor", 32'(sensor), 0);
      check("rst_veh_count", 32'(veh_count), 0);
      check("rst_fault", 32'(fault), 0);
    end
    rst = 1'b0; sensor_raw = 1'b0;
    repeat (5) tick();

    // Short glitch is ignored.
    sensor_raw = 1'b1;
    repeat (10) tick();
    sensor_raw = 1'b0;
    repeat (30) tick();
    check("glitch_sensor", 32'(sensor), 0);
    check("glitch_veh_count", 32'(veh_count), 0);

    // Held edge reaches sensor after DEBOUNCE_CYC+3 clocks.
    sensor_raw = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      if (i == D + 2) check("latency_early_sensor", 32'(sensor), 0);
      if (i == D + 3) begin
        check("latency_sensor", 32'(sensor), 1);
        check("latency_veh_count", 32'(veh_count), 1);
      end
    end

    // Green serves the waiting vehicle; its departure empties the queue.
    cr_ena = 1'b1;
    repeat (3) tick();
    check("serve_sensor", 32'(sensor), 1);
    sensor_raw = 1'b0;
    repeat (25) tick();
    check("drain_sensor", 32'(sensor), 0);
    check("drain_veh_count", 32'(veh_count), 0);
    cr_ena = 1'b0;
    repeat (2) tick();
    check("idle_sensor", 32'(sensor), 0);

    // Two queued vehicles, green ends with count 2: request re-raised.
    sensor_raw = 1'b1; repeat (20) tick();
    sensor_raw = 1'b0; repeat (20) tick();
    sensor_raw = 1'b1; repeat (20) tick();
    check("queue2_veh_count", 32'(veh_count), 2);
    cr_ena = 1'b1; repeat (5) tick();
    cr_ena = 1'b0; repeat (2) tick();
    check("requeue_sensor", 32'(sensor), 1);
    check("requeue_veh_count", 32'(veh_count), 2);

    // Twenty more arrivals saturate the counter.
    repeat (20) begin
      sensor_raw = 1'b0; repeat (20) tick();
      sensor_raw = 1'b1; repeat (20) tick();
    end
    check("saturate_veh_count", 32'(veh_count), 32'(MAXC));
    check("saturate_sensor", 32'(sensor), 1);

    // Loop held occupied across STUCK_S pulses.
    rst = 1'b1; tick(); rst = 1'b0;
    sensor_raw = 1'b1;
    repeat (25) tick();
    for (int p = 1; p <= SS; p++) begin
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
      if (p == SS - 1) check("stuck_fault_early", 32'(fault), 0);
      if (p == SS) begin
        check("stuck_fault", 32'(fault), 32'(FAULT_ON));
        check("stuck_sensor", 32'(sensor), 1);
      end
      repeat (9) tick();
    end
    sensor_raw = 1'b0;
    repeat (30) tick();
    check("stuck_sticky_sensor", 32'(sensor), 1);
    check("stuck_sticky_fault", 32'(fault), 32'(FAULT_ON));
    rst = 1'b1; tick(); rst = 1'b0;
    check("stuck_rst_fault", 32'(fault), 0);

    // Randomised traffic with occasional resets.
    raw_hold = 0;
    ena_hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (raw_hold == 0) begin
        sensor_raw = ~sensor_raw;
        raw_hold = int'($urandom_range(1, 40));
      end
      if (ena_hold == 0) begin
        cr_ena = ~cr_ena;
        ena_hold = int'($urandom_range(1, 120));
      end
      raw_hold--;
      ena_hold--;
      pulse = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
